// File: rtl/pci_mem_target.sv
// Simplified PCI memory target: decodes MEMRD/MEMWR in a fixed address window and
// serves bursts from a small internal word array with a programmable wait-state count.
module pci_mem_target #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
   parameter int          ADDR_BITS   = 4,
   parameter int          WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        reset_,
   input  logic        FRAME_,
   input  logic        IRDY_,
   input  logic [3:0]  C_BE_,
   input  logic [31:0] AD_in,
   output logic        DEVSEL_,
   output logic        TRDY_,
   output logic [31:0] AD_out,
   output logic        AD_oe
);

   typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_DATA, S_TURN, S_IGNORE} state_t;

   localparam logic [3:0] CMD_MEMRD = 4'b0110;
   localparam logic [3:0] CMD_MEMWR = 4'b0111;
   localparam logic [2:0] WS        = 3'(WAIT_STATES);
   localparam logic [2:0] WS_M1     = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;
   localparam bit         HAS_WAIT  = (WAIT_STATES > 0);

   state_t                r_state, w_nxt;
   logic [2:0]            r_cnt;
   logic [ADDR_BITS-1:0]  r_idx, w_idx_inc;
   logic                  r_rd;
   logic                  r_devsel_n, r_trdy_n, r_ad_oe;
   logic [31:0]           r_ad_out;
   logic [31:0]           r_mem [2**ADDR_BITS];
   logic                  w_hit, w_abort, w_xfer;

   assign w_hit     = ((C_BE_ == CMD_MEMRD) || (C_BE_ == CMD_MEMWR)) &&
                      (AD_in[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]) &&
                      (AD_in[1:0] == 2'b00);
   assign w_abort   = FRAME_ && IRDY_;
   assign w_xfer    = (r_state == S_DATA) && !IRDY_ && !r_trdy_n;
   assign w_idx_inc = r_idx + 1'b1;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) r_state <= S_IDLE;
      else         r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE:   if (!FRAME_) w_nxt = w_hit ? S_DECODE : S_IGNORE;
         S_DECODE: w_nxt = w_abort ? S_TURN : S_WAIT;
         S_WAIT:   if (w_abort) w_nxt = S_TURN;
                   else if (r_cnt == 3'd0) w_nxt = S_DATA;
         S_DATA:   if (w_abort) w_nxt = S_TURN;
                   else if (w_xfer) begin
                      if (FRAME_)        w_nxt = S_TURN;
                      else if (HAS_WAIT) w_nxt = S_WAIT;
                   end
         S_TURN:   w_nxt = S_IDLE;
         S_IGNORE: if (w_abort) w_nxt = S_IDLE;
         default:  w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_cnt      <= 3'd0;
         r_idx      <= '0;
         r_rd       <= 1'b0;
         r_devsel_n <= 1'b1;
         r_trdy_n   <= 1'b1;
         r_ad_oe    <= 1'b0;
         r_ad_out   <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: if (!FRAME_) begin
               r_idx <= AD_in[ADDR_BITS+1:2];
               r_rd  <= (C_BE_ == CMD_MEMRD);
            end
            S_DECODE: if (!w_abort) begin
               r_devsel_n <= 1'b0;
               r_cnt      <= WS;
            end
            S_WAIT: if (w_abort) begin
               r_devsel_n <= 1'b1;
               r_trdy_n   <= 1'b1;
            end else begin
               // read turnaround: the master released AD after the address phase
               if (r_rd) r_ad_oe <= 1'b1;
               if (r_cnt == 3'd0) begin
                  r_trdy_n <= 1'b0;
                  if (r_rd) r_ad_out <= r_mem[r_idx];
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            S_DATA: if (w_abort) begin
               r_devsel_n <= 1'b1;
               r_trdy_n   <= 1'b1;
            end else if (w_xfer) begin
               r_idx <= w_idx_inc;
               if (FRAME_) begin
                  r_devsel_n <= 1'b1;
                  r_trdy_n   <= 1'b1;
               end else if (HAS_WAIT) begin
                  r_trdy_n <= 1'b1;
                  r_cnt    <= WS_M1;
               end else if (r_rd) begin
                  r_ad_out <= r_mem[w_idx_inc];
               end
            end
            S_TURN: begin
               r_devsel_n <= 1'b1;
               r_trdy_n   <= 1'b1;
               r_ad_oe    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // array is deliberately left unreset
   always_ff @(posedge clk) begin
      if (w_xfer && !r_rd) begin
         for (int k = 0; k < 4; k++)
            if (!C_BE_[k]) r_mem[r_idx][8*k +: 8] <= AD_in[8*k +: 8];
      end
   end

   assign DEVSEL_ = r_devsel_n;
   assign TRDY_   = r_trdy_n;
   assign AD_out  = r_ad_out;
   assign AD_oe   = r_ad_oe;

endmodule

// File: tb/tb_pci_mem_target.sv
// Directed bench for pci_mem_target: a bus-master task drives transactions, read data is
// checked by a scoreboard queue popped whenever the target completes a read data phase.
module tb_pci_mem_target;

   localparam logic [3:0] MEMRD = 4'b0110;
   localparam logic [3:0] MEMWR = 4'b0111;

   logic        clk = 1'b0;
   logic        reset_;
   logic        FRAME_, IRDY_;
   logic [3:0]  C_BE_;
   logic [31:0] AD_in;
   logic        DEVSEL_, TRDY_, AD_oe;
   logic [31:0] AD_out;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q [$];
   logic [31:0] g_wd [0:3];
   int          g_dev_at, g_trdy_at, g_oe_at;
   logic        g_gap_ok, g_timeout;
   logic [31:0] mon_e;

   pci_mem_target #(.BASE_ADDR(32'h0000_1000), .ADDR_BITS(4), .WAIT_STATES(1)) dut (
      .clk(clk), .reset_(reset_), .FRAME_(FRAME_), .IRDY_(IRDY_), .C_BE_(C_BE_),
      .AD_in(AD_in), .DEVSEL_(DEVSEL_), .TRDY_(TRDY_), .AD_out(AD_out), .AD_oe(AD_oe)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Read-data monitor: one pop per completed read data phase
   always @(negedge clk) begin
      if (reset_ === 1'b1 && TRDY_ === 1'b0 && IRDY_ === 1'b0 && AD_oe === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_unexpected: got %h expected no read phase", AD_out);
         end else begin
            mon_e = exp_q.pop_front();
            if (AD_out !== mon_e) begin
               errors++;
               $display("FAIL rd_data: got %h expected %h", AD_out, mon_e);
            end
         end
      end
   end

   // Master: address phase, then n data phases; optional one-cycle IRDY_ wait before phase wait_on.
   // Records the edge (counted from the address edge E0) where DEVSEL_, AD_oe, TRDY_ first go active.
   task automatic xact(input logic [31:0] addr, input logic [3:0] cmd, input int n,
                       input logic [3:0] be, input int wait_on);
      int  edge_n, cyc;
      bit  done;
      g_dev_at = -1; g_trdy_at = -1; g_oe_at = -1; g_gap_ok = 1'b1; g_timeout = 1'b0;
      @(posedge clk); #1;
      FRAME_ = 1'b0; IRDY_ = 1'b1; AD_in = addr; C_BE_ = cmd;
      @(posedge clk); #1;
      edge_n = 0;
      C_BE_  = be;
      for (int i = 0; i < n; i++) begin
         if (i == wait_on) begin
            IRDY_ = 1'b1; AD_in = 32'd0;
            @(posedge clk); #1; edge_n++;
         end
         IRDY_  = 1'b0;
         AD_in  = (cmd == MEMWR) ? g_wd[i] : 32'd0;
         FRAME_ = (i == n - 1);
         done = 1'b0; cyc = 0;
         while (!done) begin
            @(negedge clk);
            if (g_dev_at < 0 && DEVSEL_ === 1'b0) g_dev_at = edge_n;
            if (g_oe_at  < 0 && AD_oe   === 1'b1) g_oe_at  = edge_n;
            if (TRDY_ === 1'b0) begin
               if (g_trdy_at < 0) g_trdy_at = edge_n;
               done = 1'b1;
            end else if (cyc >= 20) begin
               done = 1'b1; g_timeout = 1'b1;
            end else begin
               @(posedge clk); #1; edge_n++; cyc++;
            end
         end
         if (g_timeout) begin
            chk("xfer_timeout", 32'(g_timeout), 32'd0);
            FRAME_ = 1'b1; IRDY_ = 1'b1; AD_in = 32'd0;
            return;
         end
         @(posedge clk); #1; edge_n++;
         if (i != n - 1 && TRDY_ !== 1'b1) g_gap_ok = 1'b0;
      end
      FRAME_ = 1'b1; IRDY_ = 1'b1; AD_in = 32'd0;
   endtask

   // Called right after the last transfer edge
   task automatic post_idle(input string name);
      chk({name, "_devsel_off"}, 32'(DEVSEL_), 32'd1);
      chk({name, "_trdy_off"},   32'(TRDY_),   32'd1);
      @(posedge clk); #1;
      chk({name, "_oe_off"},     32'(AD_oe),   32'd0);
   endtask

   task automatic miss(input logic [31:0] addr, input logic [3:0] cmd, input string name);
      bit quiet = 1'b1;
      @(posedge clk); #1;
      FRAME_ = 1'b0; IRDY_ = 1'b1; AD_in = addr; C_BE_ = cmd;
      @(posedge clk); #1;
      FRAME_ = 1'b1; IRDY_ = 1'b0; AD_in = 32'hFFFF_FFFF; C_BE_ = 4'b0000;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (DEVSEL_ !== 1'b1 || TRDY_ !== 1'b1 || AD_oe !== 1'b0) quiet = 1'b0;
      end
      @(posedge clk); #1;
      IRDY_ = 1'b1; AD_in = 32'd0;
      @(posedge clk); #1;
      chk(name, 32'(quiet), 32'd1);
   endtask

   initial begin
      int cyc;
      reset_ = 1'b0; FRAME_ = 1'b1; IRDY_ = 1'b1; C_BE_ = 4'd0; AD_in = 32'd0;
      #12;
      chk("rst_devsel", 32'(DEVSEL_), 32'd1);
      chk("rst_trdy",   32'(TRDY_),   32'd1);
      chk("rst_oe",     32'(AD_oe),   32'd0);
      chk("rst_adout",  AD_out,       32'd0);
      @(posedge clk); #1; reset_ = 1'b1;

      // single write, full word
      g_wd[0] = 32'hDEAD_BEEF;
      xact(32'h0000_1004, MEMWR, 1, 4'b0000, -1);
      chk("wr_devsel_edge", 32'(g_dev_at),  32'd1);
      chk("wr_trdy_edge",   32'(g_trdy_at), 32'd3);
      post_idle("wr1");

      // single read back
      exp_q.push_back(32'hDEAD_BEEF);
      xact(32'h0000_1004, MEMRD, 1, 4'b0000, -1);
      chk("rd_oe_edge",   32'(g_oe_at),   32'd2);
      chk("rd_trdy_edge", 32'(g_trdy_at), 32'd3);
      post_idle("rd1");

      // byte-enable write: only low two bytes change
      g_wd[0] = 32'h1122_3344;
      xact(32'h0000_1004, MEMWR, 1, 4'b1100, -1);
      post_idle("wr_be");
      exp_q.push_back(32'hDEAD_3344);
      xact(32'h0000_1004, MEMRD, 1, 4'b0000, -1);
      post_idle("rd_be");

      // burst write wrapping 14,15,0,1 with a master wait on word 2
      g_wd[0] = 32'h0E0E_0001; g_wd[1] = 32'h0F0F_0002;
      g_wd[2] = 32'h0000_0003; g_wd[3] = 32'h0101_0004;
      xact(32'h0000_1038, MEMWR, 4, 4'b0000, 2);
      chk("burst_wr_gap", 32'(g_gap_ok), 32'd1);
      post_idle("bwr");
      for (int i = 0; i < 4; i++) exp_q.push_back(g_wd[i]);
      xact(32'h0000_1038, MEMRD, 4, 4'b0000, -1);
      chk("burst_rd_gap", 32'(g_gap_ok), 32'd1);
      post_idle("brd");

      // misses: outside window, and non-memory command inside window
      miss(32'h0000_2000, MEMWR, "miss_window");
      miss(32'h0000_1004, 4'b0010, "miss_cmd");
      exp_q.push_back(32'h0000_0003);
      exp_q.push_back(32'h0101_0004);
      xact(32'h0000_1000, MEMRD, 2, 4'b0000, -1);
      post_idle("after_miss");

      // reset while a read sits in DATA with the master stalled
      @(posedge clk); #1;
      FRAME_ = 1'b0; IRDY_ = 1'b1; AD_in = 32'h0000_1000; C_BE_ = MEMRD;
      @(posedge clk); #1;
      C_BE_ = 4'b0000; AD_in = 32'd0;
      cyc = 0;
      while (TRDY_ !== 1'b0 && cyc < 20) begin @(negedge clk); cyc++; end
      chk("rst_mid_reach_data", 32'(TRDY_), 32'd0);
      #1 reset_ = 1'b0;
      #1;
      chk("rst_mid_devsel", 32'(DEVSEL_), 32'd1);
      chk("rst_mid_trdy",   32'(TRDY_),   32'd1);
      chk("rst_mid_oe",     32'(AD_oe),   32'd0);
      FRAME_ = 1'b1; IRDY_ = 1'b1;
      @(posedge clk); #1; reset_ = 1'b1;

      g_wd[0] = 32'hA5A5_5A5A;
      xact(32'h0000_100C, MEMWR, 1, 4'b0000, -1);
      post_idle("wr3");
      exp_q.push_back(32'hA5A5_5A5A);
      xact(32'h0000_100C, MEMRD, 1, 4'b0000, -1);
      post_idle("rd3");

      repeat (3) @(posedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
